alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle 32-bit datapath ALU. Adds a registered valid/ready handshake, serial shifts in both directions, an optional serial multiplier, signed-correct set-less-than, and registered zero/negative/overflow/error flags. Sits in the EX stage; the hazard unit stalls the pipeline while `in_ready` is low.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operation request with valid/ready, registered result
// with a one-cycle completion pulse and status flags.
interface alu_seq_if #(
   parameter int unsigned W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   ctrl;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic [W-1:0] result;
   logic         zout;
   logic         neg;
   logic         overflow;
   logic         err;

   modport master (
      output in_valid, ctrl, a, b,
      input  in_ready, out_valid, result, zout, neg, overflow, err
   );

   modport slave (
      input  in_valid, ctrl, a, b,
      output in_ready, out_valid, result, zout, neg, overflow, err
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops, serial shifts, and an optional serial
// multiplier compiled in when ALU_MUL_EN is defined (otherwise code 1000 is illegal).
module alu_seq #(
   parameter int unsigned W   = 32,
   parameter int unsigned SHW = $clog2(W)
) (
   input logic     clk,
   input logic     reset,
   alu_seq_if.slave bus
);

   localparam int unsigned CW = SHW + 1;
   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
`ifdef ALU_MUL_EN
   localparam logic [1:0] StMul   = 2'd2;
`endif

   logic [1:0]   state_q, state_d;
   logic [W-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic         dir_q, dir_d;  // 1: shift right
   logic [W-1:0] result_q, result_d;
   logic         zout_q, zout_d, neg_q, neg_d, ovf_q, ovf_d, err_q, err_d;
   logic         valid_q, valid_d;
`ifdef ALU_MUL_EN
   logic [W-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
   logic [W-1:0] acc_add;
`endif

   logic [W-1:0]   sum, diff, acc_shift, fin_res;
   logic [SHW-1:0] shamt;
   logic           add_ovf, sub_ovf, slt, accept, fin, fin_ovf, fin_err;

   assign bus.in_ready  = (state_q == StIdle) && !reset;
   assign bus.out_valid = valid_q;
   assign bus.result    = result_q;
   assign bus.zout      = zout_q;
   assign bus.neg       = neg_q;
   assign bus.overflow  = ovf_q;
   assign bus.err       = err_q;

   assign accept    = bus.in_valid && bus.in_ready;
   assign sum       = bus.a + bus.b;
   assign diff      = bus.a + ~bus.b + W'(1);
   assign add_ovf   = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
   assign sub_ovf   = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
   assign slt       = diff[W-1] ^ sub_ovf;
   assign shamt     = bus.b[SHW-1:0];
   assign acc_shift = dir_q ? (acc_q >> 1) : (acc_q << 1);
`ifdef ALU_MUL_EN
   assign acc_add   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
`ifdef ALU_MUL_EN
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
`endif
      fin      = 1'b0;
      fin_res  = '0;
      fin_ovf  = 1'b0;
      fin_err  = 1'b0;

      case (state_q)
         StIdle: begin
            if (accept) begin
               case (bus.ctrl)
                  4'b0000: begin fin = 1'b1; fin_res = bus.a & bus.b; end
                  4'b0001: begin fin = 1'b1; fin_res = bus.a | bus.b; end
                  4'b0010: begin fin = 1'b1; fin_res = sum;  fin_ovf = add_ovf; end
                  4'b0110: begin fin = 1'b1; fin_res = diff; fin_ovf = sub_ovf; end
                  4'b0111: begin fin = 1'b1; fin_res = {{(W-1){1'b0}}, slt}; end
                  4'b0011: begin fin = 1'b1; fin_res = {{(W-1){1'b0}}, bus.a[W-1]}; end
                  4'b0100, 4'b0101: begin
                     if (shamt == '0) begin
                        fin     = 1'b1;
                        fin_res = bus.a;
                     end else begin
                        state_d = StShift;
                        acc_d   = bus.a;
                        cnt_d   = {1'b0, shamt};
                        dir_d   = bus.ctrl[0];
                     end
                  end
`ifdef ALU_MUL_EN
                  4'b1000: begin
                     state_d  = StMul;
                     acc_d    = '0;
                     mcand_d  = bus.a;
                     mplier_d = bus.b;
                     cnt_d    = CW'(W);
                  end
`endif
                  default: begin fin = 1'b1; fin_err = 1'b1; end
               endcase
            end
         end
         StShift: begin
            acc_d = acc_shift;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               fin     = 1'b1;
               fin_res = acc_shift;
               state_d = StIdle;
            end
         end
`ifdef ALU_MUL_EN
         StMul: begin
            acc_d    = acc_add;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               fin     = 1'b1;
               fin_res = acc_add;
               state_d = StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Result and all flags change together, only on completion.
   always_comb begin
      result_d = result_q;
      zout_d   = zout_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      valid_d  = fin;
      if (fin) begin
         result_d = fin_res;
         zout_d   = (fin_res == '0);
         neg_d    = fin_res[W-1];
         ovf_d    = fin_ovf;
         err_d    = fin_err;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         cnt_q    <= '0;
         dir_q    <= 1'b0;
         result_q <= '0;
         zout_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
`ifdef ALU_MUL_EN
         mcand_q  <= '0;
         mplier_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         result_q <= result_d;
         zout_q   <= zout_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
`ifdef ALU_MUL_EN
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at W=32 and W=8; honours ALU_MUL_EN in its reference model.
module tb_alu_seq;

   typedef struct {
      logic [31:0] res;
      logic        zf, nf, of, ef;
      int          lat;
      int          done;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t q32[$];
   exp_t q8[$];

   alu_seq_if #(.W(32)) bus32 ();
   alu_seq_if #(.W(8))  bus8 ();

   alu_seq #(.W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
   alu_seq #(.W(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
   endtask

   // Reference: plain w-bit integer arithmetic on sign-extended/masked 64-bit values.
   function automatic exp_t model(input int w, input logic [3:0] c, input logic [31:0] x,
                                  input logic [31:0] y);
      exp_t r;
      longint unsigned mask, ux, uy, v;
      longint sx, sy, s, hi, lo;
      int amt;
      mask = (64'd1 << w) - 64'd1;
      ux   = 64'(x) & mask;
      uy   = 64'(y) & mask;
      sx   = ux[w-1] ? longint'(ux) - (longint'(1) << w) : longint'(ux);
      sy   = uy[w-1] ? longint'(uy) - (longint'(1) << w) : longint'(uy);
      hi   = (longint'(1) << (w - 1)) - 1;
      lo   = -(longint'(1) << (w - 1));
      amt  = int'(uy % 64'(w));
      v = 0; r.of = 1'b0; r.ef = 1'b0; r.lat = 0; r.done = 0;
      case (c)
         4'b0000: v = ux & uy;
         4'b0001: v = ux | uy;
         4'b0010: begin s = sx + sy; v = 64'(s) & mask; r.of = (s > hi) || (s < lo); end
         4'b0110: begin s = sx - sy; v = 64'(s) & mask; r.of = (s > hi) || (s < lo); end
         4'b0111: v = (sx < sy) ? 64'd1 : 64'd0;
         4'b0011: v = (sx < 0) ? 64'd1 : 64'd0;
         4'b0100: begin v = (ux << amt) & mask; r.lat = amt; end
         4'b0101: begin v = ux >> amt; r.lat = amt; end
`ifdef ALU_MUL_EN
         4'b1000: begin v = (ux * uy) & mask; r.lat = w; end
`endif
         default: r.ef = 1'b1;
      endcase
      r.res = v[31:0];
      r.zf  = (v == 0);
      r.nf  = v[w-1];
      return r;
   endfunction

   // Called at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic issue(input bit sel, input logic [3:0] c, input logic [31:0] x,
                        input logic [31:0] y);
      int   guard;
      exp_t e;
      guard = 0;
      if (sel) begin
         bus8.in_valid = 1'b1; bus8.ctrl = c; bus8.a = x[7:0]; bus8.b = y[7:0];
      end else begin
         bus32.in_valid = 1'b1; bus32.ctrl = c; bus32.a = x; bus32.b = y;
      end
      #1;
      while (!(sel ? bus8.in_ready : bus32.in_ready)) begin
         @(negedge clk); #1;
         guard++;
         if (guard > 100) begin
            chk("in_ready_timeout", 96'd0, 96'd1);
            break;
         end
      end
      e = model(sel ? 8 : 32, c, x, y);
      e.done = cyc + 1 + e.lat;
      if (sel) q8.push_back(e);
      else q32.push_back(e);
      @(negedge clk);
      if (sel) bus8.in_valid = 1'b0;
      else bus32.in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((q32.size() != 0 || q8.size() != 0) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("drain", 96'(q32.size() + q8.size()), 96'd0);
   endtask

   // Monitor: every completion pulse must match the oldest outstanding expectation.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (bus32.out_valid === 1'b1) begin
         if (q32.size() == 0) chk("w32_unexpected_out_valid", 96'd1, 96'd0);
         else begin
            e = q32.pop_front();
            chk("w32_op", {32'(cyc), bus32.result, 28'd0, bus32.zout, bus32.neg,
                bus32.overflow, bus32.err}, {32'(e.done), e.res, 28'd0, e.zf, e.nf, e.of, e.ef});
         end
      end
      if (bus8.out_valid === 1'b1) begin
         if (q8.size() == 0) chk("w8_unexpected_out_valid", 96'd1, 96'd0);
         else begin
            e = q8.pop_front();
            chk("w8_op", {32'(cyc), 24'd0, bus8.result, 28'd0, bus8.zout, bus8.neg,
                bus8.overflow, bus8.err}, {32'(e.done), e.res, 28'd0, e.zf, e.nf, e.of, e.ef});
         end
      end
   end

   initial begin
      bus32.in_valid = 1'b0; bus32.ctrl = '0; bus32.a = '0; bus32.b = '0;
      bus8.in_valid  = 1'b0; bus8.ctrl  = '0; bus8.a  = '0; bus8.b  = '0;
      repeat (2) @(negedge clk);
      chk("reset_state_w32", 96'({bus32.in_ready, bus32.out_valid, bus32.result, bus32.zout,
          bus32.neg, bus32.overflow, bus32.err}), 96'd0);
      chk("reset_state_w8", 96'({bus8.in_ready, bus8.out_valid, bus8.result, bus8.zout,
          bus8.neg, bus8.overflow, bus8.err}), 96'd0);
      reset = 1'b0;
      #1;
      chk("in_ready_after_reset", 96'({bus32.in_ready, bus8.in_ready}), 96'd3);
      @(negedge clk);

      issue(0, 4'b0010, 32'd7, 32'd5);
      issue(0, 4'b0010, 32'h7FFF_FFFF, 32'd1);
      issue(0, 4'b0110, 32'h8000_0000, 32'd1);
      issue(0, 4'b0111, 32'h8000_0000, 32'd1);
      issue(0, 4'b0111, 32'd1, 32'h8000_0000);
      issue(0, 4'b0110, 32'd5, 32'd5);
      issue(0, 4'b0011, 32'h8000_0000, 32'd0);
      issue(0, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
      issue(0, 4'b0001, 32'hF000_0000, 32'h0000_000F);
      issue(0, 4'b0100, 32'd1, 32'd31);
      issue(0, 4'b0010, 32'd3, 32'd4);
      issue(0, 4'b0101, 32'h8000_0000, 32'd4);
      issue(0, 4'b0100, 32'h1234_5678, 32'd32);
      issue(0, 4'b1000, 32'h0001_0003, 32'h0001_0005);
      issue(0, 4'b1111, 32'd9, 32'd9);
      drain();

      // Reset ten cycles into a multiply: nothing may complete, outputs clear.
      issue(0, 4'b1000, 32'h0001_0003, 32'h0001_0005);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      q32.delete();
      q8.delete();
      @(negedge clk); #1;
      chk("mid_op_reset", 96'({bus32.in_ready, bus32.out_valid, bus32.result, bus32.zout,
          bus32.neg, bus32.overflow, bus32.err}), 96'd0);
      reset = 1'b0;
      @(negedge clk);
      issue(0, 4'b0010, 32'd1, 32'd1);
      drain();

      issue(1, 4'b0010, 32'h7F, 32'h01);
      issue(1, 4'b0100, 32'h01, 32'd7);
      issue(1, 4'b1111, 32'h12, 32'h34);
      issue(1, 4'b1000, 32'h13, 32'h0B);

      for (int i = 0; i < 120; i++) begin
         issue(0, 4'($urandom_range(0, 15)), $urandom, $urandom);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      for (int i = 0; i < 60; i++) begin
         issue(1, 4'($urandom_range(0, 15)), $urandom, $urandom);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
